// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: control sequencer for the KxK systolic conv array.
// Walks CLR -> LDW -> STRM -> DRAIN -> FIN for one HxW feature map and
// derives every array strobe, the per-row FIFO enables and ofm_valid.
//
// Handshake: a pixel beat happens on a cycle where ifm_valid & ifm_ready are
// both high; ifm_ready is high only in STRM and never depends on ifm_valid, and
// the source must hold a presented pixel stable until the beat.
module conv_seq_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int DIM_WIDTH   = 8,
    parameter int FIFO_SIZE   = 10,
    parameter int PE_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIM_WIDTH-1:0]   ifm_w,
    input  logic [DIM_WIDTH-1:0]   ifm_h,
    input  logic                   wgt_valid,
    input  logic                   ifm_valid,
    output logic                   ifm_ready,
    output logic                   set_wgt,
    output logic                   set_ifm,
    output logic                   set_reg,
    output logic                   wr_clr,
    output logic                   rd_clr,
    output logic [KERNEL_SIZE-1:0] wr_en,
    output logic [KERNEL_SIZE-1:0] rd_en,
    output logic                   ofm_valid,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             dbg_state
);

    localparam int K    = KERNEL_SIZE;
    // Drain length: enough advancing cycles to flush the deepest tap.
    localparam int DR   = K * K * PE_LAT + K;
    // Tap delay of the last row, D(K-1); also the coordinate-tag pipe depth.
    localparam int DMAX = K * K * PE_LAT + K - 1;
    localparam int ACW  = $clog2(DMAX + 1);
    localparam int DRW  = $clog2(DR);

    localparam logic [DIM_WIDTH-1:0] K_DIM   = DIM_WIDTH'(K);
    localparam logic [DIM_WIDTH-1:0] KM1_DIM = DIM_WIDTH'(K - 1);
    localparam logic [DIM_WIDTH-1:0] ONE_DIM = DIM_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LDW   = 3'd2,
        S_STRM  = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Advancing cycles between a pixel entering the array and row i's psum leaving it.
    function automatic int tap_delay(input int i);
        return (i + 1) * K * PE_LAT + i;
    endfunction

    state_t                 state, state_nx;
    logic [DIM_WIDTH-1:0]   w_lat, h_lat;
    logic [DIM_WIDTH-1:0]   col, row;
    logic [ACW-1:0]         adv_cnt;
    logic [DRW-1:0]         drn_cnt;
    logic [DIM_WIDTH-1:0]   wcnt [K];
    logic [DMAX-1:0]        tag_sr;

    logic                   beat;
    logic                   adv;
    logic                   last_beat;
    logic                   map_bad;
    logic                   win_full;
    logic [DIM_WIDTH-1:0]   w_minus_k;

    assign beat      = ifm_valid & ifm_ready;
    assign adv       = beat | (state == S_DRAIN);
    assign last_beat = beat && (row == h_lat - ONE_DIM) && (col == w_lat - ONE_DIM);
    assign map_bad   = (w_lat < K_DIM) || (h_lat < K_DIM);
    assign win_full  = beat && (row >= KM1_DIM) && (col >= KM1_DIM);
    assign w_minus_k = w_lat - K_DIM;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CLR;
            S_CLR:   state_nx = map_bad ? S_FIN : S_LDW;
            S_LDW:   if (wgt_valid) state_nx = S_STRM;
            S_STRM:  if (last_beat) state_nx = S_DRAIN;
            S_DRAIN: if (drn_cnt == DRW'(DR - 1)) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Array strobes and FIFO enables decoded from state and the beat.
    always_comb begin
        ifm_ready = (state == S_STRM);
        set_wgt   = (state == S_LDW) && wgt_valid;
        set_ifm   = beat;
        set_reg   = adv;
        wr_clr    = (state == S_CLR);
        rd_clr    = (state == S_CLR);
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        wr_en     = '0;
        rd_en     = '0;
        for (int i = 0; i < K; i++) begin
            wr_en[i] = adv && (adv_cnt >= ACW'(tap_delay(i)));
            rd_en[i] = wr_en[i] && (wcnt[i] == w_minus_k);
        end
    end

    // Map dimensions, sampled only when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_lat <= '0;
            h_lat <= '0;
        end else if (state == S_IDLE && start) begin
            w_lat <= ifm_w;
            h_lat <= ifm_h;
        end
    end

    // Pixel position, advance/drain counters, FIFO fill counters and window tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            adv_cnt   <= '0;
            drn_cnt   <= '0;
            tag_sr    <= '0;
            ofm_valid <= 1'b0;
            for (int i = 0; i < K; i++) wcnt[i] <= '0;
        end else if (state == S_CLR) begin
            col       <= '0;
            row       <= '0;
            adv_cnt   <= '0;
            drn_cnt   <= '0;
            tag_sr    <= '0;
            ofm_valid <= 1'b0;
            for (int i = 0; i < K; i++) wcnt[i] <= '0;
        end else begin
            if (beat) begin
                if (col == w_lat - ONE_DIM) begin
                    col <= '0;
                    row <= row + ONE_DIM;
                end else begin
                    col <= col + ONE_DIM;
                end
            end
            if (adv && adv_cnt != ACW'(DMAX)) adv_cnt <= adv_cnt + ACW'(1);
            if (state == S_DRAIN) drn_cnt <= drn_cnt + DRW'(1);
            else                  drn_cnt <= '0;
            for (int i = 0; i < K; i++) begin
                if (wr_en[i] && wcnt[i] != w_minus_k) wcnt[i] <= wcnt[i] + ONE_DIM;
            end
            if (adv) begin
                for (int j = DMAX - 1; j > 0; j--) tag_sr[j] <= tag_sr[j-1];
                tag_sr[0] <= win_full;
            end
            // FIFO read latency is one cycle; the tag leaving the pipe names the window.
            ofm_valid <= rd_en[K-1] && tag_sr[DMAX-1];
        end
    end

endmodule
